// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
// Optional: define BIN_TO_BCD_LEADING_ZERO_BLANK_EN to replace leading zero digits with 4'hF.

module bin_to_bcd_serial_digit (
   input  logic [3:0] d,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout
);
   logic [3:0] adj;

   always_comb begin
      adj = (d >= 4'd5) ? d + 4'd3 : d;
   end

   assign q    = {adj[2:0], cin};
   assign cout = adj[3];
endmodule

module bin_to_bcd_serial #(
   parameter int BIN_WIDTH = 16,
   parameter int DIGITS    = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [BIN_WIDTH-1:0]  bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);
   localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state, state_nxt;
   logic [BIN_WIDTH-1:0]   sr;
   logic [DIGITS-1:0][3:0] scr, scr_nxt;
   logic [DIGITS:0]        carry;
   logic                   ovf_s;
   logic [CW-1:0]          cnt;
   logic                   accept;

   // Leading-zero blanking runs on the final scratch value, so a wrapped result is blanked too.
   function automatic logic [4*DIGITS-1:0] load_fmt(input logic [DIGITS-1:0][3:0] s);
      logic [DIGITS-1:0][3:0] r;
      r = s;
`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
      begin
         logic lead;
         lead = 1'b1;
         for (int k = DIGITS-1; k > 0; k--) begin
            if (lead && s[k] == 4'd0) r[k] = 4'hF;
            else                      lead = 1'b0;
         end
      end
`endif
      return r;
   endfunction

   assign carry[0] = sr[BIN_WIDTH-1];

   for (genvar k = 0; k < DIGITS; k++) begin : g_dig
      bin_to_bcd_serial_digit u_dig (
         .d    (scr[k]),
         .cin  (carry[k]),
         .q    (scr_nxt[k]),
         .cout (carry[k+1])
      );
   end

   assign busy   = (state == SHIFT);
   assign accept = start && (state != SHIFT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr       <= '0;
         scr      <= '0;
         ovf_s    <= 1'b0;
         cnt      <= '0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else begin
         done <= (state == DONE);
         if (state == DONE) begin
            bcd      <= load_fmt(scr);
            overflow <= ovf_s;
         end
         if (accept) begin
            sr    <= bin;
            scr   <= '0;
            ovf_s <= 1'b0;
            cnt   <= CW'(BIN_WIDTH-1);
         end else if (state == SHIFT) begin
            sr    <= sr << 1;
            scr   <= scr_nxt;
            // A bit leaving the top digit means the value no longer fits in DIGITS digits.
            ovf_s <= ovf_s | carry[DIGITS];
            if (cnt != '0) cnt <= cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Scoreboard bench for bin_to_bcd_serial: default 5-digit instance plus a 4-digit overflow instance.

module tb_bin_to_bcd_serial;
   logic        clk, reset_n;
   logic        start, busy, done, overflow;
   logic [15:0] bin;
   logic [19:0] bcd;
   logic        start4, busy4, done4, overflow4;
   logic [15:0] bin4;
   logic [15:0] bcd4;

   int checks = 0;
   int errors = 0;

   logic [20:0] q[$];
   logic [16:0] q4[$];
   logic [20:0] mexp;
   logic [16:0] mexp4;

   bin_to_bcd_serial #(.BIN_WIDTH(16), .DIGITS(5)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
   );

   bin_to_bcd_serial #(.BIN_WIDTH(16), .DIGITS(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .bin(bin4),
      .busy(busy4), .done(done4), .bcd(bcd4), .overflow(overflow4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decimal digits by division, overflow by comparison against 10^nd.
   function automatic logic [20:0] model(input int unsigned v, input int nd);
      logic [19:0] r;
      int unsigned m, lim;
      logic ovf;
      r = '0; m = v; lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      ovf = (v >= lim);
      for (int k = 0; k < nd; k++) begin
         r[4*k +: 4] = 4'(m % 10);
         m = m / 10;
      end
`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
      for (int k = nd-1; k > 0; k--) begin
         if (r[4*k +: 4] != 4'd0) break;
         r[4*k +: 4] = 4'hF;
      end
`endif
      return {ovf, r};
   endfunction

   always @(negedge clk) begin
      if (reset_n && done) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected got ovf=%0b bcd=%h, none expected", overflow, bcd);
         end else begin
            mexp = q.pop_front();
            if ({overflow, bcd} !== mexp) begin
               errors++;
               $display("FAIL result got ovf=%0b bcd=%h want ovf=%0b bcd=%h",
                        overflow, bcd, mexp[20], mexp[19:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && done4) begin
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL done4_unexpected got ovf=%0b bcd=%h, none expected", overflow4, bcd4);
         end else begin
            mexp4 = q4.pop_front();
            if ({overflow4, bcd4} !== mexp4) begin
               errors++;
               $display("FAIL result4 got ovf=%0b bcd=%h want ovf=%0b bcd=%h",
                        overflow4, bcd4, mexp4[16], mexp4[15:0]);
            end
         end
      end
   end

   task automatic do_conv(input logic [15:0] v);
      logic seen;
      @(posedge clk); #1 bin = v; start = 1'b1; q.push_back(model(v, 5));
      @(posedge clk); #1 start = 1'b0; bin = 16'($urandom);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL conv_timeout value=%0d got no done", v); end
   endtask

   task automatic do_conv4(input logic [15:0] v);
      logic seen;
      logic [20:0] m;
      m = model(v, 4);
      @(posedge clk); #1 bin4 = v; start4 = 1'b1; q4.push_back({m[20], m[15:0]});
      @(posedge clk); #1 start4 = 1'b0;
      checks++;
      if (busy4 !== 1'b1) begin errors++; $display("FAIL busy4 got %0b want 1", busy4); end
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (done4) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL conv4_timeout value=%0d got no done", v); end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 5;
      if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
      if (done !== 1'b0)     begin errors++; $display("FAIL rst_done got %0b want 0", done); end
      if (bcd !== 20'h0)     begin errors++; $display("FAIL rst_bcd got %h want 0", bcd); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b want 0", overflow); end
      if (bcd4 !== 16'h0)    begin errors++; $display("FAIL rst_bcd4 got %h want 0", bcd4); end
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL idle_done got %0b want 0", done); end
   endtask

   task automatic test_latency;
      @(posedge clk); #1 bin = 16'd1234; start = 1'b1; q.push_back(model(1234, 5));
      @(posedge clk); #1 start = 1'b0; bin = 16'd7;
      for (int k = 0; k <= 17; k++) begin
         if (k > 0) @(posedge clk);
         @(negedge clk);
         checks += 2;
         if (busy !== (k < 16)) begin
            errors++; $display("FAIL lat_busy edge+%0d got %0b want %0b", k, busy, (k < 16));
         end
         if (done !== (k == 17)) begin
            errors++; $display("FAIL lat_done edge+%0d got %0b want %0b", k, done, (k == 17));
         end
      end
   endtask

   task automatic test_values;
      do_conv(16'd65535);
      do_conv(16'd0);
      do_conv(16'd10);
      do_conv(16'd99999 - 16'd40000);
      for (int i = 0; i < 4; i++) do_conv(16'($urandom));
   endtask

   task automatic test_back_to_back;
      int pulses[$];
      @(posedge clk); #1 bin = 16'd42; start = 1'b1;
      repeat (3) q.push_back(model(42, 5));
      for (int k = 0; k < 56; k++) begin
         @(posedge clk); #1;
         if (k == 34) start = 1'b0;
         @(negedge clk);
         if (done) pulses.push_back(k);
      end
      checks++;
      if (pulses.size() != 3) begin
         errors++; $display("FAIL b2b_count got %0d want 3", pulses.size());
      end else begin
         checks += 3;
         if (pulses[0] != 17) begin errors++; $display("FAIL b2b_p0 got %0d want 17", pulses[0]); end
         if (pulses[1] != 34) begin errors++; $display("FAIL b2b_p1 got %0d want 34", pulses[1]); end
         if (pulses[2] != 51) begin errors++; $display("FAIL b2b_p2 got %0d want 51", pulses[2]); end
      end
   endtask

   task automatic test_ignore_start;
      int n;
      @(posedge clk); #1 bin = 16'd300; start = 1'b1; q.push_back(model(300, 5));
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 bin = 16'd777; start = 1'b1;
      @(posedge clk); #1 start = 1'b0; bin = 16'd0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) n++;
      end
      checks++;
      if (n != 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", n); end
   endtask

   task automatic test_overflow;
      do_conv4(16'd12345);
      do_conv4(16'd9999);
      do_conv4(16'd65535);
      do_conv4(16'd5);
   endtask

   task automatic test_reset_mid;
      int n;
      @(posedge clk); #1 bin = 16'd500; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      checks += 4;
      if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy got %0b want 0", busy); end
      if (done !== 1'b0)     begin errors++; $display("FAIL mid_done got %0b want 0", done); end
      if (bcd !== 20'h0)     begin errors++; $display("FAIL mid_bcd got %h want 0", bcd); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %0b want 0", overflow); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      n = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done) n++;
      end
      checks++;
      if (n != 0) begin errors++; $display("FAIL mid_nodone got %0d want 0", n); end
      do_conv(16'd9876);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; bin = '0; start4 = 1'b0; bin4 = '0;
      test_reset;
      test_latency;
      test_values;
      test_back_to_back;
      test_ignore_start;
      test_overflow;
      do_conv4(16'd4321);
      test_reset_mid;
      repeat (3) @(posedge clk);
      checks += 2;
      if (q.size() != 0)  begin errors++; $display("FAIL sb_left got %0d want 0", q.size()); end
      if (q4.size() != 0) begin errors++; $display("FAIL sb4_left got %0d want 0", q4.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bin_to_bcd_serial.md
Name: bin_to_bcd_serial

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method, one bit per clock.
- Sits directly upstream of the seven-segment digit decoders.
- Each 4-bit output digit feeds one decoder instance; the decoder's "code > 9 = all segments off" behaviour is used for blanking.
- Start/busy/done handshake so a counter or register file can request a conversion and then hold the result.

Parameters:
- BIN_WIDTH, 16: width of the binary input, >= 1.
- DIGITS, 5: number of BCD digits produced, >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only when busy=0.
- bin  in  BIN_WIDTH  unsigned value to convert; sampled in the cycle start is accepted.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse when bcd has been updated.
- bcd  out  4*DIGITS  result; digit k occupies bits [4k+3:4k]; digit 0 is the least significant.
- overflow  out  1  high when the last result exceeded 10^DIGITS-1; valid with done, held until the next done.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift and scratch registers cleared.
- States:
  - IDLE: if start=1, latch bin into the shift register, clear the BCD scratch and the overflow scratch, then go to SHIFT with bit counter = BIN_WIDTH-1. Otherwise stay in IDLE.
  - SHIFT: each cycle, every scratch digit >= 5 gets +3 (4-bit arithmetic, no carry between digits). Then {scratch, shift register} shifts left one bit. A 1 shifted out of the top scratch digit sets the overflow scratch (sticky). When the counter reaches 0, go to DONE; otherwise decrement.
  - DONE: load bcd from the scratch and overflow from the overflow scratch; done=1 for exactly this cycle. If start=1, accept the new request exactly as IDLE does and go to SHIFT. Otherwise go to IDLE.
- busy=1 in SHIFT only; busy=0 in IDLE and DONE.
- Latency: start accepted at edge N, last shift at edge N+BIN_WIDTH, bcd/done registered at edge N+BIN_WIDTH+1. done is therefore visible for the cycle after that edge.
- bcd and overflow change only on the DONE edge (or reset). They are stable between conversions.
- A start while busy=1 is ignored, not queued. bin changes while busy have no effect.
- Overflow: when overflow=1, bcd holds the low DIGITS digits of the true decimal value (modulo 10^DIGITS).
- Reset asserted mid-conversion: immediate return to the reset state. No done pulse, and the previous bcd is lost (cleared to 0).
- BIN_WIDTH=1: a single SHIFT cycle; the latency rule above still holds.

Optional Feature:
- Macro: BIN_TO_BCD_LEADING_ZERO_BLANK_EN.
- Defined: in the DONE load, every leading zero digit is replaced with 4'hF, scanning from digit DIGITS-1 downward until the first nonzero digit. The decoder then renders these digits blank. Digit 0 is never blanked, so a value of 0 shows a single "0". Blanking is evaluated on the wrapped value when overflow=1.
- Not defined: bcd is the plain BCD result, with zeros kept.

Test Plan:
- Defaults, bin=16'd1234, start pulse at edge N: busy high from N; done only in the cycle after edge N+17; bcd=20'h01234, overflow=0. With the blank macro, bcd=20'hF1234.
- bin=16'd65535: bcd=20'h65535, overflow=0. Then bin=0: bcd=20'h00000. With the blank macro, bcd=20'hFFFF0.
- start held high continuously with bin=16'd42: done pulses every 17 cycles (DONE cycle re-accepts); bcd=20'h00042 each time.
- start pulsed again mid-conversion with a different bin: ignored; the result matches the first bin, and only one done pulse occurs.
- DIGITS=4, bin=16'd12345: bcd=16'h2345, overflow=1. The next conversion of bin=16'd9999 gives bcd=16'h9999, overflow=0.
- reset_n driven low 5 cycles after start: busy, done, bcd and overflow go to 0 immediately. No done pulse follows. A fresh start after release converts correctly.
